// File: rtl/pll_reset_ce_seq_pkg.sv
// Shared types and phase-point helpers for the PLL reset / 6809 clock-enable sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // Registered strobe/level bundle driven toward the CPU cores
  typedef struct packed {
    logic q_rise;
    logic e_rise;
    logic q_fall;
    logic e_fall;
    logic cpu_q;
    logic cpu_e;
  } ce_t;

  // Q leads E by a quarter period; each strobe lands on one quarter boundary
  localparam int Q_RISE_PT = 0;

  function automatic int e_rise_pt(input int ce_div);
    return ce_div / 4;
  endfunction

  function automatic int q_fall_pt(input int ce_div);
    return ce_div / 2;
  endfunction

  function automatic int e_fall_pt(input int ce_div);
    return (3 * ce_div) / 4;
  endfunction

endpackage

// File: rtl/pll_reset_ce_seq_if.sv
// Signal bundle between the sequencer and the surrounding system / game core.
interface pll_seq_if;
  logic       pll_locked;
  logic       soft_reset;
  logic       core_reset;
  logic       ready;
  logic       q_rise;
  logic       e_rise;
  logic       q_fall;
  logic       e_fall;
  logic       cpu_q;
  logic       cpu_e;
  logic [1:0] state_dbg;

  modport master (
    input  pll_locked, soft_reset,
    output core_reset, ready, q_rise, e_rise, q_fall, e_fall, cpu_q, cpu_e, state_dbg
  );

  modport slave (
    output pll_locked, soft_reset,
    input  core_reset, ready, q_rise, e_rise, q_fall, e_fall, cpu_q, cpu_e, state_dbg
  );
endinterface

// File: rtl/pll_reset_ce_seq_lock_sync.sv
// Multi-flop synchroniser bringing the asynchronous PLL lock flag into clk_sys.
module lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_ce_seq.sv
// Qualifies PLL lock, sequences core reset and generates 6809 E/Q quadrature enables,
// releasing reset on an E falling strobe so the CPUs start on a clean bus cycle.
module pll_reset_ce_seq
  import pll_seq_pkg::*;
#(
  parameter int CE_DIV       = 24,
  parameter int LOCK_STABLE  = 1024,
  parameter int RESET_CYCLES = 4096,
  parameter int SYNC_STAGES  = 2
) (
  input  logic      clk_sys,
  input  logic      rst_n,
  pll_seq_if.master bus
);

  localparam int PW = $clog2(CE_DIV);
  localparam int SW = $clog2(LOCK_STABLE);
  localparam int HW = $clog2(RESET_CYCLES);

  localparam logic [PW-1:0] PH_LAST   = PW'(CE_DIV - 1);
  localparam logic [PW-1:0] PH_Q_RISE = PW'(Q_RISE_PT);
  localparam logic [PW-1:0] PH_E_RISE = PW'(e_rise_pt(CE_DIV));
  localparam logic [PW-1:0] PH_Q_FALL = PW'(q_fall_pt(CE_DIV));
  localparam logic [PW-1:0] PH_E_FALL = PW'(e_fall_pt(CE_DIV));
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);

  logic          locked_s;
  state_t        state_q,      state_d;
  logic [PW-1:0] phase_q,      phase_d;
  logic [SW-1:0] stab_cnt_q,   stab_cnt_d;
  logic [HW-1:0] hold_cnt_q,   hold_cnt_d;
  ce_t           ce_q,         ce_d;
  logic          core_reset_q, core_reset_d;
  logic          ready_q,      ready_d;

  lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk    (clk_sys),
    .rst_n  (rst_n),
    .async_i(bus.pll_locked),
    .sync_o (locked_s)
  );

  // NOTE: every combinational output gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = '0;
    hold_cnt_d = '0;

    if (!locked_s) begin
      state_d = ST_WAIT_LOCK;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: state_d = ST_STABLE;
        ST_STABLE: begin
          if (stab_cnt_q == STAB_LAST) state_d = ST_HOLD;
          else                         stab_cnt_d = stab_cnt_q + 1'b1;
        end
        ST_HOLD: begin
          if (soft_reset_active()) begin
            hold_cnt_d = '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q;
            if (ce_q.e_fall) state_d = ST_RUN;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        ST_RUN: if (soft_reset_active()) state_d = ST_HOLD;
        default: state_d = ST_WAIT_LOCK;
      endcase
    end

    // The divider free-runs through soft resets and restarts at 0 on every lock qualification
    phase_d = '0;
    if (state_q != ST_WAIT_LOCK && state_d != ST_WAIT_LOCK) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    end

    ce_d = '0;
    if (state_d != ST_WAIT_LOCK) begin
      ce_d.q_rise = (phase_d == PH_Q_RISE);
      ce_d.e_rise = (phase_d == PH_E_RISE);
      ce_d.q_fall = (phase_d == PH_Q_FALL);
      ce_d.e_fall = (phase_d == PH_E_FALL);
      ce_d.cpu_q  = (phase_d < PH_Q_FALL);
      ce_d.cpu_e  = (phase_d >= PH_E_RISE) && (phase_d < PH_E_FALL);
    end

    core_reset_d = (state_d != ST_RUN);
    ready_d      = (state_d == ST_RUN);
  end

  function automatic logic soft_reset_active();
    return bus.soft_reset;
  endfunction

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT_LOCK;
      phase_q      <= '0;
      stab_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      ce_q         <= '0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      stab_cnt_q   <= stab_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      ce_q         <= ce_d;
      core_reset_q <= core_reset_d;
      ready_q      <= ready_d;
    end
  end

  assign bus.core_reset = core_reset_q;
  assign bus.ready      = ready_q;
  assign bus.q_rise     = ce_q.q_rise;
  assign bus.e_rise     = ce_q.e_rise;
  assign bus.q_fall     = ce_q.q_fall;
  assign bus.e_fall     = ce_q.e_fall;
  assign bus.cpu_q      = ce_q.cpu_q;
  assign bus.cpu_e      = ce_q.cpu_e;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_pll_reset_ce_seq.sv
// Directed bench for pll_reset_ce_seq with CE_DIV=8, LOCK_STABLE=16, RESET_CYCLES=32.
module tb_pll_reset_ce_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   base     = 0;

  pll_seq_if bus_if ();

  pll_reset_ce_seq #(
    .CE_DIV      (8),
    .LOCK_STABLE (16),
    .RESET_CYCLES(32),
    .SYNC_STAGES (2)
  ) dut (
    .clk_sys(clk),
    .rst_n  (rst_n),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wire [5:0] obs_ce  = {bus_if.q_rise, bus_if.e_rise, bus_if.q_fall, bus_if.e_fall,
                        bus_if.cpu_q, bus_if.cpu_e};
  wire [9:0] obs_all = {bus_if.state_dbg, bus_if.core_reset, bus_if.ready, obs_ce};

  localparam logic [9:0] WAIT_VEC = {2'd0, 1'b1, 1'b0, 6'b000000};

  // {q_rise, e_rise, q_fall, e_fall, cpu_q, cpu_e} for period offset o (CE_DIV = 8)
  function automatic logic [5:0] exp_ce(input int o);
    int p;
    p = o % 8;
    return {p == 0, p == 2, p == 4, p == 6, p < 4, (p >= 2) && (p < 6)};
  endfunction

  // Lock-to-run sequence: STABLE 0..15, HOLD 16..54 (hold_cnt 31 at 47, e_fall at 54), RUN from 55
  function automatic logic [9:0] seq_exp(input int o);
    logic [1:0] st;
    st = (o < 16) ? 2'd1 : ((o < 55) ? 2'd2 : 2'd3);
    return {st, o < 55, o >= 55, exp_ce(o)};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.pll_locked = 1'b0;
    bus_if.soft_reset = 1'b0;
    repeat (3) step();
    checks++;
    if (obs_all !== WAIT_VEC) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", obs_all, WAIT_VEC);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_no_lock();
    for (int i = 0; i < 500; i++) begin
      checks++;
      if (obs_all !== WAIT_VEC) begin
        failures++;
        $display("FAIL no_lock cyc=%0d got=%h exp=%h", cyc, obs_all, WAIT_VEC);
      end
      step();
    end
  endtask

  task automatic test_lock_sequence();
    bus_if.pll_locked = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      step();
      checks++;
      if (obs_all !== WAIT_VEC) begin
        failures++;
        $display("FAIL lock_sync_latency k=%0d got=%h exp=%h", k, obs_all, WAIT_VEC);
      end
    end
    step();
    base = cyc;
    for (int o = 0; o < 65; o++) begin
      checks++;
      if (obs_all !== seq_exp(o)) begin
        failures++;
        $display("FAIL lock_seq o=%0d got=%h exp=%h", o, obs_all, seq_exp(o));
      end
      step();
    end
  endtask

  task automatic test_lock_drop_run();
    bus_if.pll_locked = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      checks++;
      if (obs_all !== {2'd3, 1'b0, 1'b1, exp_ce(cyc - base)}) begin
        failures++;
        $display("FAIL drop_latency k=%0d got=%h exp=%h", k, obs_all,
                 {2'd3, 1'b0, 1'b1, exp_ce(cyc - base)});
      end
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (obs_all !== WAIT_VEC) begin
        failures++;
        $display("FAIL drop_wait k=%0d got=%h exp=%h", k, obs_all, WAIT_VEC);
      end
    end
  endtask

  task automatic test_relock_glitch();
    bus_if.pll_locked = 1'b1;
    repeat (3) step();
    base = cyc;
    for (int o = 0; o < 11; o++) begin
      checks++;
      if (obs_all !== seq_exp(o)) begin
        failures++;
        $display("FAIL glitch_stable o=%0d got=%h exp=%h", o, obs_all, seq_exp(o));
      end
      if (o == 8) bus_if.pll_locked = 1'b0;
      if (o == 9) bus_if.pll_locked = 1'b1;
      step();
    end
    checks++;
    if (obs_all !== WAIT_VEC) begin
      failures++;
      $display("FAIL glitch_wait got=%h exp=%h", obs_all, WAIT_VEC);
    end
    step();
    base = cyc;
    for (int o = 0; o < 65; o++) begin
      checks++;
      if (obs_all !== seq_exp(o)) begin
        failures++;
        $display("FAIL relock_seq o=%0d got=%h exp=%h", o, obs_all, seq_exp(o));
      end
      step();
    end
  endtask

  task automatic test_soft_reset();
    int s;
    int run_at;
    logic [9:0] exp;
    for (int k = 0; k < 8 && ((cyc - base) % 8) != 1; k++) step();
    s = cyc - base;
    bus_if.soft_reset = 1'b1;
    step();
    bus_if.soft_reset = 1'b0;
    // HOLD from s+1, hold_cnt saturates at s+32, release on the next e_fall offset
    run_at = s + 32;
    while ((run_at % 8) != 6) run_at++;
    run_at++;
    for (int o = s + 1; o < run_at + 8; o++) begin
      exp = {(o < run_at) ? 2'd2 : 2'd3, o < run_at, o >= run_at, exp_ce(o)};
      checks++;
      if (obs_all !== exp) begin
        failures++;
        $display("FAIL soft_reset o=%0d got=%h exp=%h", o, obs_all, exp);
      end
      step();
    end
  endtask

  task automatic test_async_reset_mid_hold();
    bus_if.soft_reset = 1'b1;
    step();
    bus_if.soft_reset = 1'b0;
    repeat (4) step();
    checks++;
    if (bus_if.state_dbg !== 2'd2) begin
      failures++;
      $display("FAIL pre_rst_hold got=%0d exp=2", bus_if.state_dbg);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_all !== WAIT_VEC) begin
      failures++;
      $display("FAIL async_rst_immediate got=%h exp=%h", obs_all, WAIT_VEC);
    end
    step();
    checks++;
    if (obs_all !== WAIT_VEC) begin
      failures++;
      $display("FAIL async_rst_held got=%h exp=%h", obs_all, WAIT_VEC);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      step();
      checks++;
      if (obs_all !== WAIT_VEC) begin
        failures++;
        $display("FAIL post_rst_sync k=%0d got=%h exp=%h", k, obs_all, WAIT_VEC);
      end
    end
    step();
    checks++;
    if (obs_all !== {2'd1, 1'b1, 1'b0, exp_ce(0)}) begin
      failures++;
      $display("FAIL post_rst_stable got=%h exp=%h", obs_all, {2'd1, 1'b1, 1'b0, exp_ce(0)});
    end
  endtask

  initial begin
    test_reset();
    test_no_lock();
    test_lock_sequence();
    test_lock_drop_run();
    test_relock_glitch();
    test_soft_reset();
    test_async_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
